// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared entry type, bypass-select constant and select-width helper for the hazard scoreboard
package hazard_pkg;
  localparam int MAX_REG_W = 8;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic valid;
    logic wr;
    logic [MAX_REG_W-1:0] dst;
    logic load;
  } entry_t;
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side bundle (decode inputs, flush, stage data in; ready/forward/stall/count out)
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 16
);
  import hazard_pkg::*;
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int SEL_W = sel_w(DEPTH);
  logic id_valid_i;
  logic id_ready_o;
  logic [NUM_SRC*REG_W-1:0] id_src_i;
  logic [NUM_SRC-1:0] id_src_used_i;
  logic id_wr_i;
  logic [REG_W-1:0] id_dst_i;
  logic id_load_i;
  logic flush_i;
  logic [DEPTH*DATA_W-1:0] stage_data_i;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_o;
  logic [NUM_SRC*DATA_W-1:0] fwd_data_o;
  logic stall_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master (
    output id_valid_i, id_src_i, id_src_used_i, id_wr_i, id_dst_i, id_load_i, flush_i, stage_data_i,
    input id_ready_o, fwd_sel_o, fwd_data_o, stall_o, stall_cnt_o
  );
  modport slave (
    input id_valid_i, id_src_i, id_src_used_i, id_wr_i, id_dst_i, id_load_i, flush_i, stage_data_i,
    output id_ready_o, fwd_sel_o, fwd_data_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard_fwd_match.sv
// fwd_match: youngest-match priority search of one decode source over the tracked entries (ent_i, src_i, used_i, valid_i -> idx_o, hit_o, nr_o)
module fwd_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int REG_W = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W = 2
) (
  input  entry_t [DEPTH-1:0] ent_i,
  input  logic [REG_W-1:0]   src_i,
  input  logic               used_i,
  input  logic               valid_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic               hit_o,
  output logic               nr_o
);
  // Scan oldest to youngest so the youngest match overwrites; the not-ready flag follows that same entry.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    nr_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (ent_i[k].valid && ent_i[k].wr && ent_i[k].dst == MAX_REG_W'(src_i) && used_i && valid_i) begin
        hit_o = 1'b1;
        idx_o = SEL_W'(k);
        nr_o = ent_i[k].load && (k < LOAD_READY);
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-write tracker with youngest-source bypass select, load-use interlock, flush and saturating stall counter (clk, rst active-low async, sb slave bundle)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH = 3,
  parameter int NUM_SRC = 2,
  parameter int LOAD_READY = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int SEL_W = sel_w(DEPTH);
  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0] hit, nr;
  logic [SEL_W-1:0] idx [NUM_SRC];
  logic stall;
  genvar s;
  for (s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(.DEPTH(DEPTH), .REG_W(REG_W), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)) u_match (
      .ent_i(ent_q),
      .src_i(sb.id_src_i[s*REG_W +: REG_W]),
      .used_i(sb.id_src_used_i[s]),
      .valid_i(sb.id_valid_i),
      .idx_o(idx[s]),
      .hit_o(hit[s]),
      .nr_o(nr[s])
    );
    assign sb.fwd_sel_o[s*SEL_W +: SEL_W] = hit[s] ? idx[s] + 1'b1 : SEL_W'(FWD_RF);
    assign sb.fwd_data_o[s*DATA_W +: DATA_W] = hit[s] ? sb.stage_data_i[int'(idx[s])*DATA_W +: DATA_W] : '0;
  end
  assign stall = |nr;
  assign sb.stall_o = stall;
  assign sb.id_ready_o = ~stall;
  assign sb.stall_cnt_o = cnt_q;
  // Flush and stall both insert a bubble; older entries always advance.
  always_comb begin
    ent_d[0] = (sb.flush_i || stall || !sb.id_valid_i) ? '0
             : entry_t'{valid: 1'b1, wr: sb.id_wr_i, dst: MAX_REG_W'(sb.id_dst_i), load: sb.id_load_i};
    for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
    cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed + random stimulus checked against an in-flight instruction list model
module tb_hazard_scoreboard;
  import hazard_pkg::*;
  localparam int NR = 8, DW = 16, D = 3, NS = 2, RW = 3, SW = 2, LR = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.NUM_REGS(NR), .DATA_W(DW), .DEPTH(D), .NUM_SRC(NS), .CNT_W(16)) h ();
  hazard_scoreboard_if #(.NUM_REGS(NR), .DATA_W(DW), .DEPTH(D), .NUM_SRC(NS), .CNT_W(4)) hs ();
  assign hs.id_valid_i = h.id_valid_i;
  assign hs.id_src_i = h.id_src_i;
  assign hs.id_src_used_i = h.id_src_used_i;
  assign hs.id_wr_i = h.id_wr_i;
  assign hs.id_dst_i = h.id_dst_i;
  assign hs.id_load_i = h.id_load_i;
  assign hs.flush_i = h.flush_i;
  assign hs.stage_data_i = h.stage_data_i;
  hazard_scoreboard #(.NUM_REGS(NR), .DATA_W(DW), .DEPTH(D), .NUM_SRC(NS), .LOAD_READY(LR), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .sb(h.slave));
  hazard_scoreboard #(.NUM_REGS(NR), .DATA_W(DW), .DEPTH(D), .NUM_SRC(NS), .LOAD_READY(LR), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .sb(hs.slave));
  typedef struct {bit v; bit wr; bit ld; int dst;} rec_t;
  rec_t pipe[$];
  int stalls;
  int n_tests = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clear_model();
    rec_t b;
    b = '{v: 0, wr: 0, ld: 0, dst: 0};
    pipe = {};
    repeat (D) pipe.push_back(b);
    stalls = 0;
  endtask
  task automatic set_in(input bit v, input int s0, input int s1, input bit [1:0] used, input bit wr,
                        input int dst, input bit ld, input bit fl, input logic [D*DW-1:0] data);
    h.id_valid_i = v;
    h.id_src_i = {RW'(s1), RW'(s0)};
    h.id_src_used_i = used;
    h.id_wr_i = wr;
    h.id_dst_i = RW'(dst);
    h.id_load_i = ld;
    h.flush_i = fl;
    h.stage_data_i = data;
  endtask
  // Expected outputs: youngest in-flight writer of each used source; a load is usable only from LR stages on.
  task automatic step();
    bit st;
    int sel, cnt4;
    logic [DW-1:0] dat;
    rec_t n;
    @(negedge clk);
    st = 0;
    for (int s = 0; s < NS; s++) begin
      sel = 0;
      dat = '0;
      for (int k = 0; k < D; k++)
        if (pipe[k].v && pipe[k].wr && pipe[k].dst == int'(h.id_src_i[s*RW +: RW]) && h.id_src_used_i[s] && h.id_valid_i) begin
          sel = k + 1;
          dat = h.stage_data_i[k*DW +: DW];
          if (pipe[k].ld && k < LR) st = 1;
          break;
        end
      check($sformatf("fwd_sel%0d", s), 64'(h.fwd_sel_o[s*SW +: SW]), 64'(sel));
      check($sformatf("fwd_data%0d", s), 64'(h.fwd_data_o[s*DW +: DW]), 64'(dat));
    end
    cnt4 = stalls > 15 ? 15 : stalls;
    check("stall", 64'(h.stall_o), 64'(st));
    check("id_ready", 64'(h.id_ready_o), 64'(!st));
    check("stall_cnt", 64'(h.stall_cnt_o), 64'(stalls));
    check("stall_cnt_sat", 64'(hs.stall_cnt_o), 64'(cnt4));
    @(posedge clk);
    if (st) stalls++;
    if (h.flush_i || st || !h.id_valid_i) n = '{v: 0, wr: 0, ld: 0, dst: 0};
    else n = '{v: 1, wr: h.id_wr_i, ld: h.id_load_i, dst: int'(h.id_dst_i)};
    void'(pipe.pop_back());
    pipe.push_front(n);
    #1;
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, 64'(h.id_ready_o), 64'd1);
    check({tag, "_stall"}, 64'(h.stall_o), 64'd0);
    check({tag, "_sel"}, 64'(h.fwd_sel_o), 64'd0);
    check({tag, "_data"}, 64'(h.fwd_data_o), 64'd0);
    check({tag, "_cnt"}, 64'(h.stall_cnt_o), 64'd0);
    check({tag, "_cnt4"}, 64'(hs.stall_cnt_o), 64'd0);
  endtask
  initial begin
    clear_model();
    set_in(1, 1, 1, 2'b11, 1, 1, 0, 0, '0);
    #12;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Back-to-back ALU dependency
    set_in(1, 0, 0, 2'b00, 1, 1, 0, 0, '0);
    step();
    set_in(1, 1, 0, 2'b01, 1, 5, 0, 0, {16'h0, 16'h0, 16'h1234});
    step();
    // Load-use: two stall cycles then forward from WB
    set_in(1, 0, 0, 2'b00, 1, 2, 1, 0, '0);
    step();
    set_in(1, 2, 0, 2'b01, 1, 6, 0, 0, {16'hBEEF, 16'h0, 16'h0});
    repeat (3) step();
    // Priority: youngest of two writers to r3
    set_in(1, 0, 0, 2'b00, 1, 3, 0, 0, '0); step();
    set_in(1, 0, 0, 2'b00, 1, 7, 0, 0, '0); step();
    set_in(1, 0, 0, 2'b00, 1, 3, 0, 0, '0); step();
    set_in(1, 3, 3, 2'b11, 0, 0, 0, 0, {16'h0002, 16'h0, 16'h0001}); step();
    // Younger load must not be masked by older ready ALU write
    set_in(1, 0, 0, 2'b00, 1, 3, 0, 0, '0); step();
    set_in(1, 0, 0, 2'b00, 1, 7, 0, 0, '0); step();
    set_in(1, 0, 0, 2'b00, 1, 3, 1, 0, '0); step();
    set_in(1, 0, 3, 2'b10, 0, 0, 0, 0, {16'h0002, 16'h0, 16'h0001}); step(); step();
    // Flush during stall
    set_in(1, 0, 0, 2'b00, 1, 4, 1, 0, '0); step();
    set_in(1, 4, 0, 2'b01, 1, 5, 0, 1, '0); step();
    set_in(0, 4, 0, 2'b01, 0, 0, 0, 0, '0); step(); step();
    // Unused source and non-writing instruction
    set_in(1, 0, 0, 2'b00, 1, 5, 0, 0, '0); step();
    set_in(1, 5, 5, 2'b00, 0, 6, 0, 0, '1); step();
    set_in(1, 0, 0, 2'b00, 0, 6, 1, 0, '0); step();
    set_in(1, 6, 6, 2'b11, 0, 0, 0, 0, '1); step();
    // Ten load-use pairs for saturation
    repeat (10) begin
      set_in(1, 0, 0, 2'b00, 1, 7, 1, 0, '0); step();
      set_in(1, 7, 7, 2'b11, 0, 0, 0, 0, {16'h7777, 16'h0, 16'h0}); repeat (3) step();
    end
    check("sat_hold", 64'(hs.stall_cnt_o), 64'd15);
    // Random stimulus biased towards hazards
    repeat (2000) begin
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 9) < 4,
             $urandom_range(0, 9) == 0, {16'($urandom), 16'($urandom), 16'($urandom)});
      step();
    end
    // Reset mid-operation with a pending load
    set_in(1, 0, 0, 2'b00, 1, 1, 0, 0, '0); step();
    set_in(1, 0, 0, 2'b00, 1, 2, 0, 0, '0); step();
    set_in(1, 0, 0, 2'b00, 1, 3, 1, 0, '0); step();
    set_in(1, 3, 2, 2'b11, 0, 0, 0, 0, {16'hAAAA, 16'hBBBB, 16'hCCCC});
    #2;
    check("pre_reset_stall", 64'(h.stall_o), 64'd1);
    rst = 1'b0;
    #1;
    reset_checks("async_reset");
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready", 64'(h.id_ready_o), 64'd1);
    step();
    set_in(1, 0, 0, 2'b00, 1, 2, 1, 0, '0); step();
    set_in(1, 2, 0, 2'b01, 0, 0, 0, 0, {16'h1111, 16'h2222, 16'h3333}); repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
